pipelined_sorter: RTL and testbench



---
 rtl/sorter_pkg.sv | 20 ++
 rtl/pipelined_sorter_cas.sv | 46 ++++
 rtl/pipelined_sorter.sv | 152 +++++++++++++++
 tb/tb_pipelined_sorter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared types and elaboration helpers for the odd-even transposition sorter.
// Used by cas_cell and pipelined_sorter; optional argsort tags are enabled by SORTER_TAG_EN.
package sorter_pkg;

   typedef enum logic {
      ASC  = 1'b0,
      DESC = 1'b1
   } cas_dir_e;

   // Tag width never drops below one bit so degenerate sizes still elaborate.
   function automatic int TAG_W(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Layer k pairs (i, i+1) where i has the same parity as k.
   function automatic bit pair_active(input int layer, input int i, input int n);
      return ((i % 2) == (layer % 2)) && (i + 1 < n);
   endfunction

endpackage

// File: rtl/pipelined_sorter_cas.sv
// Combinational compare-and-swap of one adjacent pair; equal keys never swap, keeping the sort stable.
// Tag ports exist only when SORTER_TAG_EN is defined.
module cas_cell
   import sorter_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int SIGNED = 1,
   parameter int TW     = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  cas_dir_e         dir,
`ifdef SORTER_TAG_EN
   input  logic [TW-1:0]    a_tag,
   input  logic [TW-1:0]    b_tag,
   output logic [TW-1:0]    lo_tag,
   output logic [TW-1:0]    hi_tag,
`endif
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   logic a_gt_b;
   logic a_lt_b;
   logic swap;

   always_comb begin
      if (SIGNED != 0) begin
         a_gt_b = $signed(a) > $signed(b);
         a_lt_b = $signed(a) < $signed(b);
      end else begin
         a_gt_b = a > b;
         a_lt_b = a < b;
      end
   end

   assign swap = (dir == DESC) ? a_lt_b : a_gt_b;
   assign lo   = swap ? b : a;
   assign hi   = swap ? a : b;

`ifdef SORTER_TAG_EN
   assign lo_tag = swap ? b_tag : a_tag;
   assign hi_tag = swap ? a_tag : b_tag;
`endif

endmodule

// File: rtl/pipelined_sorter.sv
// N-layer odd-even transposition sorter, one register per layer: N-cycle latency, 1 vector/cycle.
// Whole pipe stalls while out_valid && !out_ready; SORTER_TAG_EN adds the out_tag argsort port.
module pipelined_sorter
   import sorter_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int N      = 8,
   parameter int SIGNED = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N*WIDTH-1:0]     in_data,
   input  logic                   in_descend,
   output logic                   out_valid,
   input  logic                   out_ready,
`ifdef SORTER_TAG_EN
   output logic [N*TAG_W(N)-1:0]  out_tag,
`endif
   output logic [N*WIDTH-1:0]     out_data
);

   localparam int TW = TAG_W(N);

   if (N < 2) begin : g_bad_n
      $error("pipelined_sorter: N must be at least 2");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("pipelined_sorter: WIDTH must be at least 1");
   end

   typedef logic [WIDTH-1:0] elem_t;

   elem_t    cas_in  [N][N];
   elem_t    cas_out [N][N];
   cas_dir_e cas_dir [N];
   elem_t    lay_dat [N][N];
   logic     lay_vld [N];
   cas_dir_e lay_dir [N];
   logic     adv;

   // One global enable: either everything shifts or everything holds.
   assign out_valid = lay_vld[N-1];
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;

   assign cas_dir[0] = cas_dir_e'(in_descend);

   for (genvar i = 0; i < N; i++) begin : g_io
      assign cas_in[0][i]                = in_data[i*WIDTH +: WIDTH];
      assign out_data[i*WIDTH +: WIDTH]  = lay_dat[N-1][i];
   end

   for (genvar k = 1; k < N; k++) begin : g_link
      assign cas_dir[k] = lay_dir[k-1];
      for (genvar i = 0; i < N; i++) begin : g_elem
         assign cas_in[k][i] = lay_dat[k-1][i];
      end
   end

`ifdef SORTER_TAG_EN
   typedef logic [TW-1:0] tag_t;

   tag_t cas_tag_in  [N][N];
   tag_t cas_tag_out [N][N];
   tag_t lay_tag     [N][N];

   for (genvar i = 0; i < N; i++) begin : g_tag_io
      assign cas_tag_in[0][i]      = TW'(i);
      assign out_tag[i*TW +: TW]   = lay_tag[N-1][i];
   end

   for (genvar k = 1; k < N; k++) begin : g_tag_link
      for (genvar i = 0; i < N; i++) begin : g_elem
         assign cas_tag_in[k][i] = lay_tag[k-1][i];
      end
   end
`endif

   for (genvar k = 0; k < N; k++) begin : g_layer
      for (genvar i = 0; i < N; i++) begin : g_slot
         if (pair_active(k, i, N)) begin : g_cas
            cas_cell #(
               .WIDTH  (WIDTH),
               .SIGNED (SIGNED),
               .TW     (TW)
            ) u_cas (
               .a      (cas_in[k][i]),
               .b      (cas_in[k][i+1]),
               .dir    (cas_dir[k]),
`ifdef SORTER_TAG_EN
               .a_tag  (cas_tag_in[k][i]),
               .b_tag  (cas_tag_in[k][i+1]),
               .lo_tag (cas_tag_out[k][i]),
               .hi_tag (cas_tag_out[k][i+1]),
`endif
               .lo     (cas_out[k][i]),
               .hi     (cas_out[k][i+1])
            );
         end else if (!(i > 0 && pair_active(k, i - 1, N))) begin : g_pass
            // Edge element with no partner in this layer.
            assign cas_out[k][i] = cas_in[k][i];
`ifdef SORTER_TAG_EN
            assign cas_tag_out[k][i] = cas_tag_in[k][i];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            lay_vld[k] <= 1'b0;
            lay_dir[k] <= ASC;
            for (int i = 0; i < N; i++) begin
               lay_dat[k][i] <= '0;
            end
         end
      end else if (adv) begin
         lay_vld[0] <= in_valid;
         for (int k = 1; k < N; k++) begin
            lay_vld[k] <= lay_vld[k-1];
         end
         for (int k = 0; k < N; k++) begin
            lay_dir[k] <= cas_dir[k];
            for (int i = 0; i < N; i++) begin
               lay_dat[k][i] <= cas_out[k][i];
            end
         end
      end
   end

`ifdef SORTER_TAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
               lay_tag[k][i] <= '0;
            end
         end
      end else if (adv) begin
         for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
               lay_tag[k][i] <= cas_tag_out[k][i];
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipelined_sorter.sv
// Bench for pipelined_sorter (N=4, WIDTH=8): a signed and an unsigned instance share stimulus,
// expectations are queued at each input handshake and compared at each output handshake.
module tb_pipelined_sorter;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int TW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic           in_valid;
   logic           in_descend;
   logic           out_ready;
   logic [N*W-1:0] in_data;
   logic           in_ready_s, in_ready_u;
   logic           out_valid_s, out_valid_u;
   logic [N*W-1:0] out_data_s, out_data_u;
`ifdef SORTER_TAG_EN
   logic [N*TW-1:0] out_tag_s, out_tag_u;
`endif

   pipelined_sorter #(.WIDTH(W), .N(N), .SIGNED(1)) dut_s (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready_s),
      .in_data    (in_data),
      .in_descend (in_descend),
      .out_valid  (out_valid_s),
      .out_ready  (out_ready),
`ifdef SORTER_TAG_EN
      .out_tag    (out_tag_s),
`endif
      .out_data   (out_data_s)
   );

   pipelined_sorter #(.WIDTH(W), .N(N), .SIGNED(0)) dut_u (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready_u),
      .in_data    (in_data),
      .in_descend (in_descend),
      .out_valid  (out_valid_u),
      .out_ready  (out_ready),
`ifdef SORTER_TAG_EN
      .out_tag    (out_tag_u),
`endif
      .out_data   (out_data_u)
   );

   typedef struct {
      logic [31:0] ds;
      logic [31:0] du;
      logic [7:0]  ts;
      logic [7:0]  tu;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t        sb[$];
   exp_t        nxt;
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          rmode  = 0;
   bit          acc;
   bit          stalled;
   bit          last_vld;
   logic [31:0] held_s, held_u;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] p4(input logic [7:0] e0, input logic [7:0] e1,
                                      input logic [7:0] e2, input logic [7:0] e3);
      return {e3, e2, e1, e0};
   endfunction

   function automatic logic [7:0] t4(input int t0, input int t1, input int t2, input int t3);
      return 8'(t3 * 64 + t2 * 16 + t1 * 4 + t0);
   endfunction

   // Rank-based stable sort: element i lands after every element that strictly precedes it.
   function automatic void model(input logic [31:0] d, input logic desc, input bit sgn,
                                 output logic [31:0] od, output logic [7:0] ot);
      od = '0;
      ot = '0;
      for (int i = 0; i < N; i++) begin
         int         r;
         logic [7:0] ki;
         r  = 0;
         ki = d[i*W +: W];
         for (int j = 0; j < N; j++) begin
            logic [7:0] kj;
            bit         lt, gt;
            kj = d[j*W +: W];
            lt = sgn ? ($signed(kj) < $signed(ki)) : (kj < ki);
            gt = sgn ? ($signed(kj) > $signed(ki)) : (kj > ki);
            if (j != i && ((desc ? gt : lt) || (kj == ki && j < i))) r++;
         end
         od[r*W +: W]   = ki;
         ot[r*TW +: TW] = TW'(i);
      end
   endfunction

   task automatic tick();
      exp_t e;
      if (rmode == 1) out_ready = ~out_ready;
      else if (rmode == 2) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cyc++;
      check("in_ready", {31'b0, in_ready_s}, {31'b0, (!out_valid_s || out_ready)});
      check("valid_pair", {31'b0, out_valid_u}, {31'b0, out_valid_s});
      if (stalled) begin
         check("stall_valid", {31'b0, out_valid_s}, 32'd1);
         check("stall_data_s", out_data_s, held_s);
         check("stall_data_u", out_data_u, held_u);
      end
      if (out_valid_s && out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_out", {31'b0, out_valid_s}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("data_signed", out_data_s, e.ds);
            check("data_unsigned", out_data_u, e.du);
`ifdef SORTER_TAG_EN
            check("tag_signed", {24'b0, out_tag_s}, {24'b0, e.ts});
            check("tag_unsigned", {24'b0, out_tag_u}, {24'b0, e.tu});
`endif
            if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd4);
         end
      end
      last_vld = out_valid_s;
      stalled  = out_valid_s && !out_ready;
      held_s   = out_data_s;
      held_u   = out_data_u;
      acc      = in_valid && in_ready_s;
      if (acc) begin
         nxt.cyc = cyc;
         sb.push_back(nxt);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic desc,
                       input logic [31:0] ds, input logic [31:0] du,
                       input logic [7:0] ts, input logic [7:0] tu, input bit lat);
      in_valid   = 1'b1;
      in_data    = d;
      in_descend = desc;
      nxt.ds = ds; nxt.du = du; nxt.ts = ts; nxt.tu = tu; nxt.lat = lat;
      acc = 1'b0;
      for (int k = 0; k < 64 && !acc; k++) tick();
      if (!acc) check("accept_timeout", {31'b0, acc}, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic send_model(input logic [31:0] d, input logic desc);
      logic [31:0] ds, du;
      logic [7:0]  ts, tu;
      model(d, desc, 1'b1, ds, ts);
      model(d, desc, 1'b0, du, tu);
      send(d, desc, ds, du, ts, tu, 1'b0);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int k = 0; k < 200 && sb.size() != 0; k++) tick();
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_descend = 1'b0;
      in_data    = '0;
      out_ready  = 1'b1;
      stalled    = 1'b0;
      #1;
      check("rst_out_valid", {31'b0, out_valid_s}, 32'd0);
      check("rst_out_data", out_data_s, 32'd0);
      check("rst_in_ready", {31'b0, in_ready_s}, 32'd1);
`ifdef SORTER_TAG_EN
      check("rst_out_tag", {24'b0, out_tag_s}, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // Single push with exact latency and a one-cycle output pulse.
      send(p4(3, 1, 2, 0), 1'b0, p4(0, 1, 2, 3), p4(0, 1, 2, 3),
           t4(3, 1, 2, 0), t4(3, 1, 2, 0), 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("lat_idle", {31'b0, last_vld}, 32'd0);
      end
      tick();
      check("lat_hit", {31'b0, last_vld}, 32'd1);
      tick();
      check("lat_pulse", {31'b0, last_vld}, 32'd0);

      // Signed versus unsigned ordering, then descending with ties.
      send(p4(8'h80, 8'h7F, 8'h00, 8'hFF), 1'b0,
           p4(8'h80, 8'hFF, 8'h00, 8'h7F), p4(8'h00, 8'h7F, 8'h80, 8'hFF),
           t4(0, 3, 2, 1), t4(2, 1, 0, 3), 1'b1);
      send(p4(5, 5, 9, 1), 1'b1, p4(9, 5, 5, 1), p4(9, 5, 5, 1),
           t4(2, 0, 1, 3), t4(2, 0, 1, 3), 1'b1);
      drain();

      // Back-to-back with alternating direction under a toggling out_ready.
      rmode = 1;
      for (int i = 0; i < 8; i++) send_model($urandom, i[0]);
      drain();
      rmode     = 0;
      out_ready = 1'b1;

      // Reset while three vectors are in flight and the head is stalled.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_model($urandom, 1'b0);
      for (int k = 0; k < 3; k++) tick();
      check("pre_rst_valid", {31'b0, out_valid_s}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'b0, out_valid_s}, 32'd0);
      check("mid_rst_data", out_data_s, 32'd0);
      check("mid_rst_ready", {31'b0, in_ready_s}, 32'd1);
      sb.delete();
      stalled = 1'b0;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      send(p4(8'hFE, 8'h02, 8'h01, 8'h7F), 1'b1,
           p4(8'h7F, 8'h02, 8'h01, 8'hFE), p4(8'hFE, 8'h7F, 8'h02, 8'h01),
           t4(3, 1, 2, 0), t4(0, 3, 1, 2), 1'b1);
      drain();

      // Random traffic with random valid gaps and random out_ready.
      rmode = 2;
      for (int v = 0; v < 10000; v++) begin
         if ($urandom_range(0, 3) == 0) tick();
         send_model($urandom & 32'h3F3F_3F3F | ($urandom_range(0, 1) ? 32'hC0C0_C0C0 : 32'h0),
                    $urandom_range(0, 1) != 0);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
